// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pkg
// Description : Shared types and constants for the motor PWM controller and
//               its sibling display/fan blocks. Holds the speed-mode
//               encoding, default duty percentages, the remain-seconds
//               width and the speed-advance helper.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

    // Speed modes as shown on o_mode
    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_LOW  = 2'd1,
        MODE_MID  = 2'd2,
        MODE_HIGH = 2'd3
    } mode_t;

    // Default duty cycles in percent
    localparam int unsigned c_duty_low_def  = 25;
    localparam int unsigned c_duty_mid_def  = 50;
    localparam int unsigned c_duty_high_def = 75;

    // Width of the remaining-seconds counter
    localparam int unsigned c_remain_w = 8;

    // Speed button sequence: OFF->LOW->MID->HIGH->LOW (never back to OFF)
    function automatic mode_t next_speed(input mode_t m);
        case (m)
            MODE_OFF:  return MODE_LOW;
            MODE_LOW:  return MODE_MID;
            MODE_MID:  return MODE_HIGH;
            default:   return MODE_LOW;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_pwm_fsm_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_gen
// Description : Registered PWM comparator with a period-synchronous
//               threshold latch. The threshold is captured only while
//               i_load is high, so a new duty takes effect at a period
//               boundary and never produces a runt pulse.
// Ports       : i_clk     - clock
//               i_reset_n - synchronous active-low reset
//               i_cnt     - free-running period counter
//               i_thresh  - candidate threshold (high while cnt < thresh)
//               i_load    - latch strobe (period start, or forced update)
//               o_pwm     - registered PWM output
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_gen #(
    parameter int CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W:0]   i_thresh,
    input  logic             i_load,
    output logic             o_pwm
);

    logic [CNT_W:0] r_thresh;
    logic [CNT_W:0] w_thresh_eff;

    // On a load cycle the freshly presented threshold is used for the
    // compare immediately, so the first cycle of a period already follows
    // the new duty.
    assign w_thresh_eff = i_load ? i_thresh : r_thresh;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_thresh <= '0;
            o_pwm    <= 1'b0;
        end else begin
            if (i_load) begin
                r_thresh <= i_thresh;
            end
            o_pwm <= ({1'b0, i_cnt} < w_thresh_eff);
        end
    end

endmodule
`default_nettype wire

// File: rtl/motor_pwm_fsm.sv
`default_nettype none
// ============================================================================
// Module      : motor_pwm_fsm
// Description : DC motor speed controller. A mode FSM (OFF/LOW/MID/HIGH)
//               driven by debounced button pulses selects the PWM duty; an
//               auto-off countdown returns the motor to OFF on expiry.
// Ports       : i_clk          - system clock
//               i_reset_n      - synchronous active-low reset
//               i_btn_speed    - 1-cycle pulse, advance speed
//               i_btn_off      - 1-cycle pulse, stop motor and clear timer
//               i_btn_timer    - 1-cycle pulse, add a timer step
//               o_pwm          - registered motor PWM
//               o_mode         - 0=OFF 1=LOW 2=MID 3=HIGH
//               o_timer_active - countdown running
//               o_remain_sec   - seconds remaining (0 when inactive)
// Revision    : 1.0 - initial release
// ============================================================================
module motor_pwm_fsm
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD     = 1000,
    parameter int DUTY_LOW       = c_duty_low_def,
    parameter int DUTY_MID       = c_duty_mid_def,
    parameter int DUTY_HIGH      = c_duty_high_def,
    parameter int TICKS_PER_SEC  = 100_000_000,
    parameter int TIMER_STEP_SEC = 5,
    parameter int TIMER_MAX_SEC  = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_btn_speed,
    input  logic                  i_btn_off,
    input  logic                  i_btn_timer,
    output logic                  o_pwm,
    output logic [1:0]            o_mode,
    output logic                  o_timer_active,
    output logic [c_remain_w-1:0] o_remain_sec
);

    localparam int c_cnt_w   = $clog2(PWM_PERIOD);
    localparam int c_presc_w = $clog2(TICKS_PER_SEC);

    localparam logic [c_cnt_w-1:0]   c_cnt_last   = c_cnt_w'(PWM_PERIOD - 1);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICKS_PER_SEC - 1);

    // Duty thresholds in counter cycles (integer truncation)
    localparam logic [c_cnt_w:0] c_thr_low  = (c_cnt_w + 1)'(PWM_PERIOD * DUTY_LOW  / 100);
    localparam logic [c_cnt_w:0] c_thr_mid  = (c_cnt_w + 1)'(PWM_PERIOD * DUTY_MID  / 100);
    localparam logic [c_cnt_w:0] c_thr_high = (c_cnt_w + 1)'(PWM_PERIOD * DUTY_HIGH / 100);

    localparam logic [c_remain_w:0] c_step9 = (c_remain_w + 1)'(TIMER_STEP_SEC);
    localparam logic [c_remain_w:0] c_max9  = (c_remain_w + 1)'(TIMER_MAX_SEC);

    mode_t                  r_mode;
    mode_t                  w_mode_nxt;
    logic [c_remain_w-1:0]  r_remain;
    logic [c_remain_w-1:0]  w_remain_nxt;
    logic [c_presc_w-1:0]   r_presc;
    logic [c_presc_w-1:0]   w_presc_nxt;
    logic [c_cnt_w-1:0]     r_pwm_cnt;
    logic [c_remain_w:0]    w_sum9;
    logic                   w_active;
    logic                   w_tick;
    logic [c_cnt_w:0]       w_thr;
    logic                   w_load;

    assign w_active = (r_remain != '0);
    assign w_tick   = w_active && (r_presc == c_presc_last);
    assign w_sum9   = {1'b0, r_remain} + c_step9;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_mode    <= MODE_OFF;
            r_remain  <= '0;
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_remain  <= w_remain_nxt;
            r_presc   <= w_presc_nxt;
            r_pwm_cnt <= (r_pwm_cnt == c_cnt_last) ? '0 : r_pwm_cnt + c_cnt_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next-state: off > expiry > speed; a timer press beats a plain tick
    // ------------------------------------------------------------------
    always_comb begin
        w_mode_nxt   = r_mode;
        w_remain_nxt = r_remain;

        if (i_btn_off) begin
            w_mode_nxt   = MODE_OFF;
            w_remain_nxt = '0;
        end else if (w_tick && (r_remain == c_remain_w'(1))) begin
            w_mode_nxt   = MODE_OFF;
            w_remain_nxt = '0;
        end else begin
            if (i_btn_speed) begin
                w_mode_nxt = next_speed(r_mode);
            end
            if (i_btn_timer && (r_mode != MODE_OFF)) begin
                w_remain_nxt = (w_sum9 > c_max9) ? '0 : w_sum9[c_remain_w-1:0];
            end else if (w_tick) begin
                w_remain_nxt = r_remain - c_remain_w'(1);
            end
        end

        // Prescaler idles at 0 while inactive, so a fresh start (0->nonzero)
        // always begins a full second.
        if (!w_active || (w_remain_nxt == '0) || w_tick) begin
            w_presc_nxt = '0;
        end else begin
            w_presc_nxt = r_presc + c_presc_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Duty selection; OFF forces a zero threshold without waiting for the
    // period boundary.
    // ------------------------------------------------------------------
    always_comb begin
        w_thr = '0;
        case (r_mode)
            MODE_LOW:  w_thr = c_thr_low;
            MODE_MID:  w_thr = c_thr_mid;
            MODE_HIGH: w_thr = c_thr_high;
            default:   w_thr = '0;
        endcase
    end

    assign w_load = (r_pwm_cnt == '0) || (r_mode == MODE_OFF);

    pwm_gen #(
        .CNT_W (c_cnt_w)
    ) u_pwm_gen (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_cnt     (r_pwm_cnt),
        .i_thresh  (w_thr),
        .i_load    (w_load),
        .o_pwm     (o_pwm)
    );

    assign o_mode         = r_mode;
    assign o_timer_active = w_active;
    assign o_remain_sec   = r_remain;

endmodule
`default_nettype wire
